sprite_frame_sequencer: RTL and testbench
=========================================

# sprite_frame_sequencer

Sequencer that drives the frame-select inputs of the robot icon sprite renderer. It maps BotInfo orientation to a sprite-sheet row and runs a ping-pong walk animation across the sheet columns while the robot moves. All frame changes are committed only on a video frame boundary, so the icon never tears mid-scan. It sits between the BotInfo register and the icon address generator, in the pixel clock domain.

## Interface
- ANIMATION_COUNTDOWN, 8_000_000: clk cycles per animation step; must be ≥ 2.
- NUM_COLS, 3: sprite-sheet columns; fixed at 3, used for range checks.
- clk  in  1  pixel/system clock.
- reset  in  1  asynchronous, active-high reset.
- BotInfo_reg  in  8  [2:0] orientation (N, NE, E, SE, S, SW, W, NW), [7:4] speed; nonzero means moving.
- frame_start  in  1  single-cycle pulse at the start of vertical blank.
- anim_enable  in  1  1 = animation runs; 0 = column frozen.
- frame_row  out  3  sprite-sheet row for the renderer.
- frame_col  out  2  sprite-sheet column, range 0..2.
- frame_update  out  1  single-cycle pulse when row or column changed.

One clock; reset is asynchronous and active-high.

## Operation
- **Orientation to row map:** 0→1, 1→7, 2→3, 3→5, 4→0, 5→4, 6→2, 7→6.
- **moving** = (BotInfo_reg[7:4] != 0), sampled every cycle.
- **FSM states:** STOPPED, FWD, BWD.
- **STOPPED → FWD** when moving. The counter is reloaded to ANIMATION_COUNTDOWN-1 on entry.
- **FWD/BWD → STOPPED** when !moving. The column target becomes 1, and the counter reloads and holds.
- **Step counter:** $clog2(ANIMATION_COUNTDOWN) bits, counts down by 1 per cycle while in FWD or BWD and anim_enable=1.
  - At 0, it raises expire, reloads to ANIMATION_COUNTDOWN-1, and sets sticky pending_step.
  - Multiple expiries before one frame_start coalesce into a single step.
- **Step application** happens only at frame_start with (pending_step | expire):
  - FWD: col+1. On reaching 2, switch to BWD.
  - BWD: col-1. On reaching 0, switch to FWD.
  - pending_step clears.
- **frame_start, all states:**
  - frame_row ← map(BotInfo_reg[2:0]) sampled that cycle.
  - In STOPPED, frame_col ← 1.
  - frame_update asserts next cycle iff frame_row or frame_col value changed.
- **anim_enable = 0:** counter and pending_step hold; frame_col does not step. frame_row and STOPPED handling still apply.
- **Outputs between frame_start pulses** hold their values regardless of BotInfo_reg changes.

## Timing
- **Reset values:** frame_row=1, frame_col=1, frame_update=0, state=STOPPED, counter=ANIMATION_COUNTDOWN-1, pending_step=0.
- **Output latency:** frame_row and frame_col are registered; they change in the cycle after the frame_start edge, together with the frame_update pulse.
- **First step from standstill:** with moving asserted at cycle t, expire occurs at t+ANIMATION_COUNTDOWN. The step appears after the next frame_start at or after that cycle.
- **Expire and frame_start in the same cycle:** the step is applied at that frame_start, and pending_step ends at 0.
- **Moving drops in the same cycle as frame_start:** the STOPPED rule wins, giving col=1 with no step.
- **frame_start held high for multiple cycles:** this is illegal. The block only requires that each high cycle is treated as a commit.
- **Reset asserted mid-animation:** all state returns to reset values asynchronously. The first commit after release follows the normal rules.
- **frame_col never leaves 0..2.** Reaching value 3 is an assertion failure.

## Structure
- **Package robot_icon_pkg:**
  - orientation_to_row() function.
  - FSM state enum.
  - SPRITE_ROWS=8 and SPRITE_COLS_PER_ROW=3 constants, shared with the icon renderer.
- **Sub-module anim_step_timer:** reloadable down-counter with enable and expire output, parameterised by ANIMATION_COUNTDOWN.
- **Top level:** FSM, pending_step flag, and output commit registers.

## Test plan
All scenarios use ANIMATION_COUNTDOWN=4.
- **Reset/idle:** release reset, BotInfo=0x02, one frame_start → frame_row=3, frame_col=1, frame_update pulses once.
- **Orientation map:** sweep BotInfo[2:0] 0..7 with speed 0, each followed by frame_start → rows 1,7,3,5,0,4,2,6.
- **Ping-pong:** BotInfo=0x10, frame_start every 5 cycles → frame_col sequence 2,1,0,1,2.
- **Coalescing:** moving, no frame_start for 20 cycles, then one frame_start → frame_col advances exactly one step.
- **Stop mid-walk / enable:**
  - At col=2, set BotInfo speed=0 and pulse frame_start → col=1, STOPPED.
  - With anim_enable=0 while moving, repeated frame_starts → col constant.
- **Async reset mid-operation:** assert reset between clock edges at col=0 → outputs return to row 1, col 1 immediately, and frame_update=0.

Source files
------------

// File: rtl/robot_icon_pkg.sv
// rtl/robot_icon_pkg.sv - sprite-sheet constants, sequencer states and orientation-to-row map
package robot_icon_pkg;

  localparam int SPRITE_ROWS         = 8;
  localparam int SPRITE_COLS_PER_ROW = 3;

  localparam logic [2:0] RESET_ROW = 3'd1;
  localparam logic [1:0] REST_COL  = 2'd1;

  typedef enum logic [1:0] {
    ST_STOPPED = 2'd0,
    ST_FWD     = 2'd1,
    ST_BWD     = 2'd2
  } anim_state_e;

  // Sheet rows are not stored in compass order, so N..NW need a remap.
  function automatic logic [2:0] orientation_to_row(input logic [2:0] orientation);
    logic [2:0] row;
    row = 3'd1;
    case (orientation)
      3'd0:    row = 3'd1;
      3'd1:    row = 3'd7;
      3'd2:    row = 3'd3;
      3'd3:    row = 3'd5;
      3'd4:    row = 3'd0;
      3'd5:    row = 3'd4;
      3'd6:    row = 3'd2;
      3'd7:    row = 3'd6;
      default: row = 3'd1;
    endcase
    return row;
  endfunction

endpackage

// File: rtl/anim_step_timer.sv
// rtl/anim_step_timer.sv - reloadable down-counter that pulses expire once per animation step
module anim_step_timer #(
  parameter int ANIMATION_COUNTDOWN = 8_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic reload,
  input  logic enable,
  output logic expire
);

  localparam int            CW         = $clog2(ANIMATION_COUNTDOWN);
  localparam logic [CW-1:0] RELOAD_VAL = CW'(ANIMATION_COUNTDOWN - 1);

  logic [CW-1:0] count_q;

  // A pending reload suppresses the expiry that would otherwise land in the same cycle.
  assign expire = enable && !reload && (count_q == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= RELOAD_VAL;
    end else if (reload || expire) begin
      count_q <= RELOAD_VAL;
    end else if (enable) begin
      count_q <= count_q - CW'(1);
    end
  end

endmodule

// File: rtl/sprite_frame_sequencer.sv
// rtl/sprite_frame_sequencer.sv - orientation row select and ping-pong walk column, committed on frame_start
module sprite_frame_sequencer
  import robot_icon_pkg::*;
#(
  parameter int ANIMATION_COUNTDOWN = 8_000_000,
  parameter int NUM_COLS            = SPRITE_COLS_PER_ROW
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] BotInfo_reg,
  input  logic       frame_start,
  input  logic       anim_enable,
  output logic [2:0] frame_row,
  output logic [1:0] frame_col,
  output logic       frame_update
);

  localparam logic [1:0] COL_LAST = 2'(NUM_COLS - 1);

  anim_state_e state_q, state_d;
  logic [1:0]  col_q, col_d;
  logic        pending_q, pending_d;
  logic [2:0]  commit_row;
  logic        moving;
  logic        stopping;
  logic        expire;
  logic        step_apply;
  logic        timer_enable;
  logic        unused_bits;

  assign moving       = |BotInfo_reg[7:4];
  assign unused_bits  = BotInfo_reg[3];
  // Standing still (or about to) pins the column target at rest and keeps the timer reloaded.
  assign stopping     = !moving || (state_q == ST_STOPPED);
  assign timer_enable = anim_enable && (state_q != ST_STOPPED);
  assign step_apply   = frame_start && !stopping && anim_enable && (pending_q || expire);
  assign commit_row   = orientation_to_row(BotInfo_reg[2:0]);

  anim_step_timer #(
    .ANIMATION_COUNTDOWN(ANIMATION_COUNTDOWN)
  ) u_step_timer (
    .clk   (clk),
    .reset (reset),
    .reload(stopping),
    .enable(timer_enable),
    .expire(expire)
  );

  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    pending_d = pending_q;
    case (state_q)
      ST_STOPPED: begin
        if (moving) state_d = ST_FWD;
      end
      ST_FWD: begin
        if (!moving) begin
          state_d = ST_STOPPED;
        end else if (step_apply) begin
          col_d = col_q + 2'd1;
          if (col_d == COL_LAST) state_d = ST_BWD;
        end
      end
      ST_BWD: begin
        if (!moving) begin
          state_d = ST_STOPPED;
        end else if (step_apply) begin
          col_d = col_q - 2'd1;
          if (col_d == 2'd0) state_d = ST_FWD;
        end
      end
      default: state_d = ST_STOPPED;
    endcase

    // Expiries between commits collapse into one sticky request.
    if (stopping) begin
      col_d     = REST_COL;
      pending_d = 1'b0;
    end else if (step_apply) begin
      pending_d = 1'b0;
    end else if (expire) begin
      pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_STOPPED;
      col_q        <= REST_COL;
      pending_q    <= 1'b0;
      frame_row    <= RESET_ROW;
      frame_col    <= REST_COL;
      frame_update <= 1'b0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      pending_q    <= pending_d;
      frame_update <= frame_start && ((commit_row != frame_row) || (col_d != frame_col));
      if (frame_start) begin
        frame_row <= commit_row;
        frame_col <= col_d;
      end
    end
  end

  a_col_in_range: assert property (@(posedge clk) disable iff (reset)
    (frame_col <= COL_LAST) && (col_q <= COL_LAST));

endmodule

// File: tb/tb_sprite_frame_sequencer.sv
// tb/tb_sprite_frame_sequencer.sv - scoreboard bench with reference model for sprite_frame_sequencer
`timescale 1ns/1ps
module tb_sprite_frame_sequencer;

  localparam int N    = 4;
  localparam int COLS = 3;

  logic       clk;
  logic       reset;
  logic [7:0] BotInfo_reg;
  logic       frame_start;
  logic       anim_enable;
  logic [2:0] frame_row;
  logic [1:0] frame_col;
  logic       frame_update;

  sprite_frame_sequencer #(
    .ANIMATION_COUNTDOWN(N),
    .NUM_COLS           (COLS)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .BotInfo_reg (BotInfo_reg),
    .frame_start (frame_start),
    .anim_enable (anim_enable),
    .frame_row   (frame_row),
    .frame_col   (frame_col),
    .frame_update(frame_update)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int row;
    int col;
    bit upd;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   row_map[8] = '{1, 7, 3, 5, 0, 4, 2, 6};

  // Reference model: walking flag, signed direction, enabled-cycle tick count since last reload.
  bit m_run;
  int m_dir;
  int m_col;
  int m_ticks;
  bit m_pend;
  int m_out_row;
  int m_out_col;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_run = 0; m_dir = 1; m_col = 1; m_ticks = 0; m_pend = 0;
    m_out_row = 1; m_out_col = 1;
  endtask

  task automatic model_step(input logic [7:0] b, input bit fs, input bit en);
    bit   mv, expire, step;
    int   c;
    exp_t e;
    mv     = (b[7:4] != 4'd0);
    expire = 0;
    if (!m_run || !mv) begin
      m_ticks = 0;
    end else if (en) begin
      m_ticks++;
      if (m_ticks == N) begin
        expire  = 1;
        m_ticks = 0;
      end
    end
    step = fs && m_run && mv && en && (m_pend || expire);
    if (fs) begin
      if (!m_run || !mv) c = 1;
      else if (step)     c = m_col + m_dir;
      else               c = m_col;
      e.row = row_map[b[2:0]];
      e.col = c;
      e.upd = (e.row != m_out_row) || (c != m_out_col);
      exp_q.push_back(e);
      m_out_row = e.row;
      m_out_col = c;
    end
    if (step) begin
      m_col += m_dir;
      if (m_col == COLS - 1) m_dir = -1;
      else if (m_col == 0)   m_dir = 1;
    end
    if (m_run && !mv) begin
      m_run = 0; m_col = 1; m_dir = 1; m_pend = 0;
    end else if (!m_run && mv) begin
      m_run = 1;
    end else if (step) begin
      m_pend = 0;
    end else if (expire) begin
      m_pend = 1;
    end
  endtask

  task automatic drive(input logic [7:0] b, input bit fs, input bit en);
    @(negedge clk);
    BotInfo_reg = b;
    frame_start = fs;
    anim_enable = en;
    @(posedge clk);
    model_step(b, fs, en);
  endtask

  task automatic walk_period(input logic [7:0] b, input bit en);
    repeat (4) drive(b, 0, en);
    drive(b, 1, en);
  endtask

  // Monitor: a queued entry means a commit just landed; otherwise outputs must hold.
  exp_t mon_e;
  int   last_row = 1;
  int   last_col = 1;
  always @(negedge clk) begin
    if (reset) begin
      last_row = 1;
      last_col = 1;
    end else if (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      check("commit_row", frame_row, mon_e.row);
      check("commit_col", frame_col, mon_e.col);
      check("commit_update", frame_update, mon_e.upd);
      last_row = mon_e.row;
      last_col = mon_e.col;
    end else begin
      check("hold_update", frame_update, 0);
      check("hold_row", frame_row, last_row);
      check("hold_col", frame_col, last_col);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int          pp_seq[5] = '{2, 1, 0, 1, 2};
  logic [7:0]  rb;
  bit          ren, rfs, last_fs;
  int          hold;
  bit          reached;

  initial begin
    reset = 1; BotInfo_reg = 8'h00; frame_start = 0; anim_enable = 1;
    model_reset();
    repeat (3) @(negedge clk);
    check("reset_row", frame_row, 1);
    check("reset_col", frame_col, 1);
    check("reset_update", frame_update, 0);
    reset = 0;

    drive(8'h02, 0, 1);
    drive(8'h02, 1, 1);
    #1;
    check("idle_row", frame_row, 3);
    check("idle_col", frame_col, 1);
    check("idle_update", frame_update, 1);

    for (int o = 0; o < 8; o++) begin
      drive(8'(o), 0, 1);
      drive(8'(o), 0, 1);
      drive(8'(o), 1, 1);
      #1;
      check("orient_row", frame_row, row_map[o]);
    end

    for (int k = 0; k < 5; k++) begin
      walk_period(8'h10, 1);
      #1;
      check("pingpong_col", frame_col, pp_seq[k]);
    end

    repeat (20) drive(8'h10, 0, 1);
    drive(8'h10, 1, 1);
    #1;
    check("coalesce_col", frame_col, 1);
    drive(8'h10, 0, 1);
    drive(8'h10, 1, 1);
    #1;
    check("coalesce_single", frame_col, 1);

    reached = 0;
    for (int k = 0; k < 12 && !reached; k++) begin
      walk_period(8'h10, 1);
      if (m_out_col == 2) reached = 1;
    end
    check("reach_col2", reached, 1);
    drive(8'h00, 1, 1);
    #1;
    check("stop_col", frame_col, 1);

    for (int k = 0; k < 6; k++) begin
      walk_period(8'h13, 0);
      #1;
      check("disabled_col", frame_col, 1);
    end

    last_fs = 0;
    for (int i = 0; i < 400; i++) begin
      hold = $urandom_range(1, 12);
      rb   = 8'($urandom);
      if ($urandom_range(0, 3) == 0) rb[7:4] = 4'd0;
      ren  = ($urandom_range(0, 9) != 0);
      for (int j = 0; j < hold; j++) begin
        rfs = !last_fs && ($urandom_range(0, 5) == 0);
        drive(rb, rfs, ren);
        last_fs = rfs;
      end
    end

    reached = 0;
    for (int k = 0; k < 20 && !reached; k++) begin
      walk_period(8'h10, 1);
      if (m_out_col == 0) reached = 1;
    end
    check("reach_col0", reached, 1);
    #2;
    reset = 1;
    BotInfo_reg = 8'h00; frame_start = 0; anim_enable = 1;
    exp_q.delete();
    model_reset();
    #1;
    check("async_reset_row", frame_row, 1);
    check("async_reset_col", frame_col, 1);
    check("async_reset_update", frame_update, 0);
    @(posedge clk);
    @(negedge clk);
    reset = 0;

    drive(8'h05, 0, 1);
    drive(8'h15, 1, 1);
    #1;
    check("post_reset_row", frame_row, 4);
    check("post_reset_col", frame_col, 1);
    check("post_reset_update", frame_update, 1);
    repeat (6) drive(8'h15, 0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
